hazard_control_unit: RTL and testbench

HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

---
 rtl/hazard_pkg.sv | 15 +
 rtl/hazard_match.sv | 19 +
 rtl/hazard_control_unit.sv | 138 +++++++++++++
 tb/tb_hazard_control_unit.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and defaults for the load-use / memory-stall hazard controller.
package hazard_pkg;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      LOAD_STALL = 2'd1,
      MEM_WAIT   = 2'd2,
      FLUSH      = 2'd3
   } hazState_t;

   localparam int REG_AW_DEF   = 5;
   localparam int LOAD_LAT_DEF = 1;
   localparam int CNT_W        = 3;   // wide enough for LOAD_LAT-1 up to 6

endpackage

// File: rtl/hazard_match.sv
// Load-use comparator: the ID instruction reads the register a load in EX
// is about to write. Register 0 never creates a dependency.
module hazard_match
   import hazard_pkg::*;
#(
   parameter int REG_AW = REG_AW_DEF
) (
   input  logic [REG_AW-1:0] idRs,
   input  logic [REG_AW-1:0] idRt,
   input  logic              idUsesRt,
   input  logic [REG_AW-1:0] exRt,
   input  logic              exMemRead,
   output logic              hazard
);

   assign hazard = exMemRead && (exRt != '0) &&
                   ((exRt == idRs) || (idUsesRt && (exRt == idRt)));

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller: load-use bubbles, data-memory freeze and
// taken-branch flush. Optional stall-cycle perf counter is built when the
// macro HAZARD_PERF_CNT_EN is defined.
module hazard_control_unit
   import hazard_pkg::*;
#(
   parameter int REG_AW   = REG_AW_DEF,
   parameter int LOAD_LAT = LOAD_LAT_DEF   // 1..7
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              id_uses_rt,
   input  logic [REG_AW-1:0] ex_rt,
   input  logic              ex_mem_read,
   input  logic              mem_busy,
   input  logic              ex_branch_taken,
   input  logic              reg_write_in,
   input  logic              mem_write_in,
   output logic              stall_pc,
   output logic              stall_ifid,
   output logic              freeze_all,
   output logic              flush_ifid,
   output logic              reg_write_safe,
   output logic              mem_write_safe
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [15:0]       stall_cycles
`endif
);

   // Extra LOAD_STALL cycles after the bubble issued from IDLE.
   localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LOAD_LAT - 1);

   hazState_t        state, stateNext, evalState;
   logic [CNT_W-1:0] cnt, cntNext;
   logic             resume, resumeNext;
   logic             hazard;
   logic             stallPc, stallIfid, freezeAll, flushIfid, bubble;

   hazard_match #(.REG_AW(REG_AW)) uMatch (
      .idRs      (id_rs),
      .idRt      (id_rt),
      .idUsesRt  (id_uses_rt),
      .exRt      (ex_rt),
      .exMemRead (ex_mem_read),
      .hazard    (hazard)
   );

   // State, remaining-stall counter and resume flag; reset wins mid-stall.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         cnt    <= '0;
         resume <= 1'b0;
      end else begin
         state  <= stateNext;
         cnt    <= cntNext;
         resume <= resumeNext;
      end
   end

   // Next state and stall controls. When memory frees up in MEM_WAIT the
   // cycle is evaluated as the state being resumed, so no idle gap appears
   // between the freeze and the rest of an interrupted load stall.
   always_comb begin
      stateNext  = state;
      cntNext    = cnt;
      resumeNext = resume;
      stallPc    = 1'b0;
      stallIfid  = 1'b0;
      freezeAll  = 1'b0;
      flushIfid  = 1'b0;
      bubble     = 1'b0;
      evalState  = state;
      if (state == MEM_WAIT && !mem_busy)
         evalState = resume ? LOAD_STALL : IDLE;

      if (mem_busy) begin
         freezeAll = 1'b1;
         stallPc   = 1'b1;
         stallIfid = 1'b1;
         stateNext = MEM_WAIT;
         if (state == LOAD_STALL)
            resumeNext = 1'b1;
         else if (state != MEM_WAIT)
            resumeNext = 1'b0;
      end else begin
         resumeNext = 1'b0;
         case (evalState)
            IDLE: begin
               if (ex_branch_taken) begin
                  // ID holds a wrong-path instruction: drop any hazard on it.
                  flushIfid = 1'b1;
                  stateNext = FLUSH;
               end else if (hazard) begin
                  stallPc   = 1'b1;
                  stallIfid = 1'b1;
                  bubble    = 1'b1;
                  cntNext   = LAT_M1;
                  stateNext = (LAT_M1 == '0) ? IDLE : LOAD_STALL;
               end else begin
                  stateNext = IDLE;
               end
            end
            LOAD_STALL: begin
               stallPc   = 1'b1;
               stallIfid = 1'b1;
               bubble    = 1'b1;
               cntNext   = (cnt == '0) ? '0 : cnt - 1'b1;
               stateNext = (cnt <= 1) ? IDLE : LOAD_STALL;
            end
            FLUSH:   stateNext = IDLE;
            default: stateNext = IDLE;
         endcase
      end
   end

   // Reset forces every control low, including the write-enable pass-through.
   assign stall_pc       = rst_n & stallPc;
   assign stall_ifid     = rst_n & stallIfid;
   assign freeze_all     = rst_n & freezeAll;
   assign flush_ifid     = rst_n & flushIfid;
   assign reg_write_safe = rst_n & reg_write_in & ~bubble;
   assign mem_write_safe = rst_n & mem_write_in & ~bubble;

`ifdef HAZARD_PERF_CNT_EN
   // Saturating count of cycles in which the PC is held.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         stall_cycles <= '0;
      else if (stallPc && stall_cycles != 16'hFFFF)
         stall_cycles <= stall_cycles + 16'd1;
   end
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit: LOAD_LAT=1 and LOAD_LAT=3 instances
// share stimulus; expected outputs are queued by the driver and checked by
// an independent monitor on the falling edge.
module tb_hazard_control_unit;

   localparam logic [5:0] ZERO = 6'b000000;
   localparam logic [5:0] PASS = 6'b000011;  // {stall_pc,stall_ifid,freeze,flush,rw,mw}
   localparam logic [5:0] BUB  = 6'b110000;
   localparam logic [5:0] FRZ  = 6'b111011;
   localparam logic [5:0] FLS  = 6'b000111;

   typedef struct {
      string       nm;
      logic [5:0]  e1;
      logic [5:0]  e3;
      logic        chkPerf;
      logic [15:0] p1;
      logic [15:0] p3;
   } exp_t;

   logic       clk;
   logic       rst_n;
   logic [4:0] id_rs, id_rt, ex_rt;
   logic       id_uses_rt, ex_mem_read, mem_busy, ex_branch_taken;
   logic       reg_write_in, mem_write_in;

   logic sp1, si1, fa1, fl1, rw1, mw1;
   logic sp3, si3, fa3, fl3, rw3, mw3;
   logic [5:0] out1, out3;
`ifdef HAZARD_PERF_CNT_EN
   logic [15:0] sc1, sc3;
`endif

   exp_t expQ[$];
   exp_t monE;
   int   checks   = 0;
   int   failures = 0;

   hazard_control_unit #(.REG_AW(5), .LOAD_LAT(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rt(id_uses_rt), .ex_rt(ex_rt), .ex_mem_read(ex_mem_read),
      .mem_busy(mem_busy), .ex_branch_taken(ex_branch_taken),
      .reg_write_in(reg_write_in), .mem_write_in(mem_write_in),
      .stall_pc(sp1), .stall_ifid(si1), .freeze_all(fa1), .flush_ifid(fl1),
      .reg_write_safe(rw1), .mem_write_safe(mw1)
`ifdef HAZARD_PERF_CNT_EN
      , .stall_cycles(sc1)
`endif
   );

   hazard_control_unit #(.REG_AW(5), .LOAD_LAT(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rt(id_uses_rt), .ex_rt(ex_rt), .ex_mem_read(ex_mem_read),
      .mem_busy(mem_busy), .ex_branch_taken(ex_branch_taken),
      .reg_write_in(reg_write_in), .mem_write_in(mem_write_in),
      .stall_pc(sp3), .stall_ifid(si3), .freeze_all(fa3), .flush_ifid(fl3),
      .reg_write_safe(rw3), .mem_write_safe(mw3)
`ifdef HAZARD_PERF_CNT_EN
      , .stall_cycles(sc3)
`endif
   );

   assign out1 = {sp1, si1, fa1, fl1, rw1, mw1};
   assign out3 = {sp3, si3, fa3, fl3, rw3, mw3};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: one queued expectation per cycle, checked mid-cycle.
   always @(negedge clk) begin
      if (expQ.size() != 0) begin
         monE = expQ.pop_front();
         checks++;
         if (out1 !== monE.e1) begin
            failures++;
            $display("FAIL %s lat1: got %b want %b", monE.nm, out1, monE.e1);
         end
         checks++;
         if (out3 !== monE.e3) begin
            failures++;
            $display("FAIL %s lat3: got %b want %b", monE.nm, out3, monE.e3);
         end
`ifdef HAZARD_PERF_CNT_EN
         if (monE.chkPerf) begin
            checks++;
            if (sc1 !== monE.p1) begin
               failures++;
               $display("FAIL %s perf1: got %h want %h", monE.nm, sc1, monE.p1);
            end
            checks++;
            if (sc3 !== monE.p3) begin
               failures++;
               $display("FAIL %s perf3: got %h want %h", monE.nm, sc3, monE.p3);
            end
         end
`endif
      end
   end

   // One cycle of stimulus plus its expected outputs for both instances.
   task automatic cyc(input string nm, input logic rstv,
                      input logic [4:0] rs, input logic [4:0] rt, input logic uses,
                      input logic [4:0] xrt, input logic rd, input logic busy,
                      input logic br, input logic rwi, input logic mwi,
                      input logic [5:0] e1, input logic [5:0] e3,
                      input logic perf = 1'b0,
                      input logic [15:0] p1 = 16'h0, input logic [15:0] p3 = 16'h0);
      exp_t e;
      @(posedge clk);
      #1;
      rst_n = rstv; id_rs = rs; id_rt = rt; id_uses_rt = uses; ex_rt = xrt;
      ex_mem_read = rd; mem_busy = busy; ex_branch_taken = br;
      reg_write_in = rwi; mem_write_in = mwi;
      e.nm = nm; e.e1 = e1; e.e3 = e3; e.chkPerf = perf; e.p1 = p1; e.p3 = p3;
      expQ.push_back(e);
   endtask

   initial begin
      rst_n = 1'b0; id_rs = '0; id_rt = '0; id_uses_rt = 1'b0; ex_rt = '0;
      ex_mem_read = 1'b0; mem_busy = 1'b0; ex_branch_taken = 1'b0;
      reg_write_in = 1'b0; mem_write_in = 1'b0;

      // reset: hazard inputs and write enables present, everything held low
      cyc("rst0", 0, 8, 0, 0, 8, 1, 0, 0, 1, 1, ZERO, ZERO, 1'b1, 16'h0, 16'h0);
      cyc("rst1", 0, 8, 0, 0, 8, 1, 1, 1, 1, 1, ZERO, ZERO, 1'b1, 16'h0, 16'h0);
      cyc("rel",  1, 0, 0, 0, 0, 0, 0, 0, 1, 1, PASS, PASS);
      cyc("pwRw0",1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 6'b000001, 6'b000001);
      cyc("pwMw0",1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 6'b000010, 6'b000010);

      // load-use on Rs
      cyc("ldA0", 1, 8, 0, 0, 8, 1, 0, 0, 1, 1, BUB,  BUB);
      cyc("ldA1", 1, 8, 0, 0, 0, 0, 0, 0, 1, 1, PASS, BUB);
      cyc("ldA2", 1, 8, 0, 0, 0, 0, 0, 0, 1, 1, PASS, BUB);
      cyc("ldA3", 1, 8, 0, 0, 0, 0, 0, 0, 1, 1, PASS, PASS);

      // no-hazard corner cases, then Rt hazard when Rt is used
      cyc("zero",   1, 0, 0, 0, 0, 1, 0, 0, 1, 1, PASS, PASS);
      cyc("rtNoUse",1, 3, 9, 0, 9, 1, 0, 0, 1, 1, PASS, PASS);
      cyc("noRead", 1, 8, 0, 0, 8, 0, 0, 0, 1, 1, PASS, PASS);
      cyc("rtUse0", 1, 3, 9, 1, 9, 1, 0, 0, 1, 1, BUB,  BUB);
      cyc("rtUse1", 1, 3, 9, 1, 0, 0, 0, 0, 1, 1, PASS, BUB);
      cyc("rtUse2", 1, 3, 9, 1, 0, 0, 0, 0, 1, 1, PASS, BUB);
      cyc("rtUse3", 1, 3, 9, 1, 0, 0, 0, 0, 1, 1, PASS, PASS);

      // memory busy for 4 cycles starting in the second stall cycle
      cyc("mb0", 1, 8, 0, 0, 8, 1, 0, 0, 1, 1, BUB,  BUB);
      cyc("mb1", 1, 8, 0, 0, 0, 0, 1, 0, 1, 1, FRZ,  FRZ);
      cyc("mb2", 1, 8, 0, 0, 0, 0, 1, 0, 1, 0, 6'b111010, 6'b111010);
      cyc("mb3", 1, 8, 0, 0, 0, 0, 1, 0, 1, 1, FRZ,  FRZ);
      cyc("mb4", 1, 8, 0, 0, 0, 0, 1, 0, 1, 1, FRZ,  FRZ);
      cyc("mb5", 1, 8, 0, 0, 0, 0, 0, 0, 1, 1, PASS, BUB);
      cyc("mb6", 1, 8, 0, 0, 0, 0, 0, 0, 1, 1, PASS, BUB);
      cyc("mb7", 1, 8, 0, 0, 0, 0, 0, 0, 1, 1, PASS, PASS);

      // taken branch beats hazard; memory busy beats branch
      cyc("br0",    1, 8, 0, 0, 8, 1, 0, 1, 1, 1, FLS,  FLS);
      cyc("br1",    1, 0, 0, 0, 0, 0, 0, 0, 1, 1, PASS, PASS);
      cyc("br2",    1, 0, 0, 0, 0, 0, 0, 0, 1, 1, PASS, PASS);
      cyc("brBusy", 1, 8, 0, 0, 8, 1, 1, 1, 1, 1, FRZ,  FRZ);
      cyc("brBusy1",1, 0, 0, 0, 0, 0, 0, 0, 1, 1, PASS, PASS);

      // reset asserted in the middle of a LOAD_LAT=3 stall
      cyc("rs0", 1, 8, 0, 0, 8, 1, 0, 0, 1, 1, BUB,  BUB);
      cyc("rs1", 0, 8, 0, 0, 8, 1, 0, 0, 1, 1, ZERO, ZERO, 1'b1, 16'h0, 16'h0);
      cyc("rs2", 1, 8, 0, 0, 0, 0, 0, 0, 1, 1, PASS, PASS);
      cyc("rs3", 1, 8, 0, 0, 0, 0, 0, 0, 1, 1, PASS, PASS);

`ifdef HAZARD_PERF_CNT_EN
      // long forced stall drives the perf counter into saturation
      cyc("satRst", 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, ZERO, ZERO, 1'b1, 16'h0, 16'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      mem_busy = 1'b1;
      repeat (70000) @(posedge clk);
      cyc("sat", 1, 0, 0, 0, 0, 0, 1, 0, 1, 1, FRZ, FRZ, 1'b1, 16'hFFFF, 16'hFFFF);
`endif

      // let the monitor consume the remaining expectations
      for (int i = 0; i < 10; i++) begin
         if (expQ.size() == 0) break;
         @(negedge clk);
         #1;
      end
      if (expQ.size() != 0) begin
         $display("FAIL drain: %0d expectations left, want 0", expQ.size());
         $fatal(1, "monitor did not drain");
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
